// File: rtl/bus_pkg.sv
// Shared definitions for the dValid/dAck byte bus: master FSM states and
// transfer timing constants.
package bus_pkg;

  typedef enum logic [1:0] {IDLE, VALID, GAP} bus_mst_state_t;

  localparam int BUS_MIN_VALID = 2;
  localparam int BUS_MAX_VALID = 4;
  localparam int BUS_DATA_W    = 8;

endpackage

// File: rtl/bus_master_tx.sv
// Upstream master for the dValid/dAck byte bus: takes bytes from a ready/valid
// source and holds dValid for MIN_VALID..MAX_VALID clocks. BUS_MASTER_RETRY_EN
// enables per-byte retries after a timeout.
module bus_master_tx
  import bus_pkg::*;
#(
  parameter int DATA_W    = BUS_DATA_W,
  parameter int MIN_VALID = BUS_MIN_VALID,
  parameter int MAX_VALID = BUS_MAX_VALID,
  parameter int RETRY_MAX = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  input  logic              dAck,
  output logic              dValid,
  output logic [DATA_W-1:0] data,
  output logic              done,
  output logic              err
);

  localparam int CW = (MAX_VALID > 1) ? $clog2(MAX_VALID) : 1;

  if (MIN_VALID < 1 || MAX_VALID < MIN_VALID || RETRY_MAX < 0) begin : g_cfg_bad
    $error("bus_master_tx: illegal MIN_VALID/MAX_VALID/RETRY_MAX");
  end

  bus_mst_state_t    state, state_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [DATA_W-1:0] hold;
  logic              load, done_d, err_d;

`ifdef BUS_MASTER_RETRY_EN
  localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  logic [RW-1:0] rty, rty_d;
  logic          rty_pend, rty_pend_d;
`endif

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    load    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef BUS_MASTER_RETRY_EN
    rty_d      = rty;
    rty_pend_d = rty_pend;
`endif
    case (state)
      IDLE: begin
        if (src_valid) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = VALID;
`ifdef BUS_MASTER_RETRY_EN
          rty_d   = '0;
`endif
        end
      end
      VALID: begin
        // ack is tested first so it wins over a same-cycle timeout
        if (dAck && cnt >= CW'(MIN_VALID - 1)) begin
          state_d = GAP;
          done_d  = 1'b1;
        end else if (cnt == CW'(MAX_VALID - 1)) begin
          state_d = GAP;
`ifdef BUS_MASTER_RETRY_EN
          if (rty < RW'(RETRY_MAX)) begin
            rty_d      = rty + 1'b1;
            rty_pend_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
`else
          err_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      GAP: begin
        cnt_d   = '0;
        state_d = IDLE;
`ifdef BUS_MASTER_RETRY_EN
        if (rty_pend) begin
          state_d    = VALID;
          rty_pend_d = 1'b0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      hold  <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
`ifdef BUS_MASTER_RETRY_EN
      rty      <= '0;
      rty_pend <= 1'b0;
`endif
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      done  <= done_d;
      err   <= err_d;
      if (load) hold <= src_data;
`ifdef BUS_MASTER_RETRY_EN
      rty      <= rty_d;
      rty_pend <= rty_pend_d;
`endif
    end
  end

  assign src_ready = (state == IDLE);
  assign dValid    = (state == VALID);
  assign data      = hold;

endmodule
